// File: rtl/ser_word_feeder_if.sv
// Upstream word handshake for ser_word_feeder.
// master = word producer, slave = feeder.
interface ser_word_feeder_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/ser_word_feeder.sv
// ser_word_feeder: parallel-to-serial feeder for a downstream right-shift
// register. It accepts a WIDTH-bit word on a valid/ready handshake and sends
// it LSB-first on sdr, one bit per clock, so that after the frame the
// downstream Q equals the word. A GAP_CYCLES idle gap follows each frame.
// Optional macro SER_PARITY_EN appends an even-parity bit to every frame.
module ser_word_feeder #(
  parameter int   WIDTH      = 4,
  parameter int   GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               clrb,
  ser_word_feeder_if.slave   up,
  output logic               sdr,
  output logic               shift_en,
  output logic               frame_done,
  output logic               busy
);

`ifdef SER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  localparam int CMAX = (WIDTH + 2 > GAP_CYCLES + 1) ? WIDTH + 2 : GAP_CYCLES + 1;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] LAST  = CW'(FLEN - 1);
  localparam logic [CW-1:0] GLAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit B2B = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [FLEN-1:0] sbuf;
  logic [FLEN-1:0] word;
  logic            last;
  logic            rdy;
  logic            accept;

  // Frame image: data bits, plus the parity bit on top when enabled, so the
  // shifter treats parity as just one more bit.
  always_comb begin
`ifdef SER_PARITY_EN
    word = {^up.din, up.din};
`else
    word = up.din;
`endif
  end

  assign last   = (state == SHIFT) && (cnt == LAST);
  // Ready in IDLE, and in the final bit cycle when frames may run back-to-back.
  assign rdy    = (state == IDLE) || (B2B && last);
  assign accept = up.din_valid && rdy;
  assign up.din_ready = rdy;

  // Control FSM with registered serial outputs. Bit 0 is loaded straight
  // from din on acceptance; the buffer keeps the remaining bits.
  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      state      <= IDLE;
      cnt        <= '0;
      sbuf       <= '0;
      sdr        <= IDLE_LEVEL;
      shift_en   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        state    <= SHIFT;
        cnt      <= '0;
        sdr      <= word[0];
        sbuf     <= word >> 1;
        shift_en <= 1'b1;
        busy     <= 1'b1;
        // Back-to-back: the previous frame completes on this same edge.
        if (last) frame_done <= 1'b1;
      end else begin
        case (state)
          SHIFT: begin
            if (cnt == LAST) begin
              frame_done <= 1'b1;
              sdr        <= IDLE_LEVEL;
              shift_en   <= 1'b0;
              cnt        <= '0;
              if (B2B) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= GAP;
              end
            end else begin
              sdr  <= sbuf[0];
              sbuf <= sbuf >> 1;
              cnt  <= cnt + 1'b1;
            end
          end
          GAP: begin
            if (cnt == GLAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ser_word_feeder.sv
// Bench for ser_word_feeder: two instances (GAP_CYCLES=1 and 0) share one
// upstream stimulus; a cycle-indexed schedule model predicts every output.
module tb_ser_word_feeder;
  localparam int W  = 4;
  localparam int NC = 3000;
  localparam int NA = NC + 16;
`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L = W + PAR;

  logic clk = 1'b0;
  logic clrb = 1'b0;
  logic vld = 1'b0;
  logic [W-1:0] din = '0;
  always #5 clk = ~clk;

  ser_word_feeder_if #(.WIDTH(W)) if_g ();
  ser_word_feeder_if #(.WIDTH(W)) if_b ();
  assign if_g.din = din;
  assign if_g.din_valid = vld;
  assign if_b.din = din;
  assign if_b.din_valid = vld;

  logic sdr_g, se_g, fd_g, busy_g;
  logic sdr_b, se_b, fd_b, busy_b;

  ser_word_feeder #(.WIDTH(W), .GAP_CYCLES(1), .IDLE_LEVEL(1'b0)) u_gap (
    .clk(clk), .clrb(clrb), .up(if_g),
    .sdr(sdr_g), .shift_en(se_g), .frame_done(fd_g), .busy(busy_g));

  ser_word_feeder #(.WIDTH(W), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_b2b (
    .clk(clk), .clrb(clrb), .up(if_b),
    .sdr(sdr_b), .shift_en(se_b), .frame_done(fd_b), .busy(busy_b));

  // Downstream right-shift registers fed by each feeder.
  logic [W-1:0] q_g, q_b;
  always_ff @(posedge clk) if (se_g) q_g <= {sdr_g, q_g[W-1:1]};
  always_ff @(posedge clk) if (se_b) q_b <= {sdr_b, q_b[W-1:1]};

  logic [1:0] o_sdr, o_se, o_fd, o_busy, o_rdy;
  logic [W-1:0] o_q [2];
  assign o_sdr  = {sdr_b, sdr_g};
  assign o_se   = {se_b, se_g};
  assign o_fd   = {fd_b, fd_g};
  assign o_busy = {busy_b, busy_g};
  assign o_rdy  = {if_b.din_ready, if_g.din_ready};
  assign o_q[0] = q_g;
  assign o_q[1] = q_b;

  // Expected outputs per instance per cycle; default is idle.
  bit           e_sdr  [2][NA];
  bit           e_se   [2][NA];
  bit           e_fd   [2][NA];
  bit           e_busy [2][NA];
  logic [W-1:0] e_q    [2][NA];
  int           free_at [2];
  int           gap [2] = '{1, 0};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int cur_d = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d got %0h exp %0h", tag, cur_d, cyc, got, exp);
    end
  endtask

  initial begin
    bit exp_rdy;
    for (int d = 0; d < 2; d++) free_at[d] = 0;
    for (int c = 0; c < NC; c++) begin
      @(posedge clk);
      #1;
      if (c < 2) begin
        clrb = 1'b0; vld = 1'b1; din = 4'hB;
      end else if (c < 40) begin
        clrb = 1'b1; vld = 1'b0; din = W'($urandom);
        case (c)
          2:  begin vld = 1'b1; din = 4'b1011; end
          12: begin vld = 1'b1; din = 4'h5; end
          13, 14, 15, 16, 17, 18: begin vld = 1'b1; din = 4'hA; end
          20, 21: begin vld = 1'b0; din = 4'hF; end
          26: begin vld = 1'b1; din = 4'b0110; end
          29: clrb = 1'b0;
          30: begin vld = 1'b1; din = 4'h3; end
          default: ;
        endcase
      end else begin
        clrb = ($urandom_range(0, 49) != 0);
        vld  = ($urandom_range(0, 9) < 7);
        din  = W'($urandom);
      end
      @(negedge clk);
      cyc = c;
      for (int d = 0; d < 2; d++) begin
        cur_d = d;
        if (!clrb) begin
          for (int j = c; j < NA; j++) begin
            e_sdr[d][j] = 1'b0; e_se[d][j] = 1'b0;
            e_fd[d][j] = 1'b0; e_busy[d][j] = 1'b0;
          end
          free_at[d] = 0;
        end
        exp_rdy = !clrb || (c >= free_at[d]);
        chk("sdr",        32'(o_sdr[d]),  32'(e_sdr[d][c]));
        chk("shift_en",   32'(o_se[d]),   32'(e_se[d][c]));
        chk("frame_done", 32'(o_fd[d]),   32'(e_fd[d][c]));
        chk("busy",       32'(o_busy[d]), 32'(e_busy[d][c]));
        chk("din_ready",  32'(o_rdy[d]),  32'(exp_rdy));
        if (e_fd[d][c] && PAR == 0) chk("q", 32'(o_q[d]), 32'(e_q[d][c]));
        if (clrb && vld && exp_rdy) begin
          for (int i = 0; i < L; i++) begin
            e_sdr[d][c+1+i] = (i < W) ? din[i] : ^din;
            e_se[d][c+1+i]  = 1'b1;
          end
          for (int i = 1; i <= L + gap[d]; i++) e_busy[d][c+i] = 1'b1;
          e_fd[d][c+L+1] = 1'b1;
          e_q[d][c+L+1]  = din;
          free_at[d] = (gap[d] == 0) ? c + L : c + L + gap[d] + 1;
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
